key_sched_ctrl: RTL

- Sequencer that drives the DES key schedule datapath (PC-1 / C-D register / rotate / PC-2) for one 16-round encryption key expansion.
- Captures a 64-bit key on a start handshake and presents it, stable, on the datapath key input.
- Generates per-round load, mux select and rotate amount, plus subkey-valid / round-index / done status for the downstream round logic.
- Sits directly upstream of the key schedule datapath and beside the round datapath consuming its 48-bit subkeys.

---
 rtl/key_sched_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/key_sched_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// key_sched_ctrl : sequences the DES key schedule datapath through 16 rounds
// Revision 1.0
// ============================================================================
module key_sched_ctrl #(
  parameter int KEY_W   = 64,
  parameter int ROUND_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               hold,
  output logic [KEY_W-1:0]   key_out,
  output logic               load,
  output logic               mux_control,
  output logic [1:0]         shift,
  output logic               busy,
  output logic               subkey_valid,
  output logic [ROUND_W-1:0] subkey_round,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [ROUND_W-1:0] C_RND_1  = ROUND_W'(1);
  localparam logic [ROUND_W-1:0] C_RND_2  = ROUND_W'(2);
  localparam logic [ROUND_W-1:0] C_RND_9  = ROUND_W'(9);
  localparam logic [ROUND_W-1:0] C_RND_16 = ROUND_W'(16);

  logic [1:0]         state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic               sv_q,    sv_d;
  logic [ROUND_W-1:0] sr_q,    sr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      key_q   <= '0;
      sv_q    <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
      sv_q    <= sv_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    sv_d    = sv_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = C_RND_1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        // Subkey status follows each datapath load, so it freezes with hold.
        if (load) begin
          sv_d = 1'b1;
          sr_d = round_q;
          if (round_q == C_RND_16) begin
            round_d = '0;
            state_d = S_FLUSH;
          end else begin
            round_d = round_q + ROUND_W'(1);
          end
        end
      end
      S_FLUSH: begin
        sv_d    = 1'b0;
        sr_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    load        = 1'b0;
    mux_control = 1'b0;
    shift       = 2'b00;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_ROUND: begin
        busy        = 1'b1;
        load        = ~hold;
        mux_control = (round_q != C_RND_1);
        // Rounds 1, 2, 9 and 16 rotate by one; all others by two (total 28).
        case (round_q)
          C_RND_1, C_RND_2, C_RND_9, C_RND_16: shift = 2'b01;
          default:                             shift = 2'b10;
        endcase
      end
      S_FLUSH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign key_out      = key_q;
  assign subkey_valid = sv_q;
  assign subkey_round = sr_q;

endmodule
`default_nettype wire
